// File: rtl/uart_tx_if.sv
// Parallel-side request and serial-side status bundle for uart_tx.
// Handshake: the word is taken when DATA_VALID=1 and BUSY=0 at a rising edge; no back-pressure, requests while BUSY are dropped.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  BUSY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output BUSY
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; one bit per CLK.
// Parity is present only when UART_TX_PARITY_EN is defined; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   bus,
  output logic [2:0] DBG_STATE
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_tx;
  logic                  r_busy;
  logic [CW-1:0]         w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 1'b1;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic w_parity;

  // Even: XOR of the word; odd: its complement. Always from the latched word.
  assign w_parity = (^r_data) ^ r_par_typ;
`else
  logic w_unused_par;
  assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_cnt     <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (bus.DATA_VALID) begin
            r_data    <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
`endif
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_tx    <= r_data[0];
          r_cnt   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          // r_cnt indexes the bit currently on the line.
          if (r_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              r_tx    <= w_parity;
              r_state <= S_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
`else
            r_tx    <= 1'b1;
            r_state <= S_STOP;
`endif
          end else begin
            r_cnt <= w_cnt_nxt;
            r_tx  <= r_data[w_cnt_nxt];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx    <= 1'b1;
          r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.BUSY   = r_busy;
  assign DBG_STATE  = r_state;
endmodule
